// File: rtl/serial_add_arbiter.sv
// rtl/serial_add_arbiter.sv - two-requester round-robin arbiter feeding one bit-serial adder
// Optional final-carry output enabled by defining SERIAL_ADD_ARB_COUT_EN.
module serial_add_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [W-1:0] res_sum
`ifdef SERIAL_ADD_ARB_COUT_EN
    ,
    output logic         res_cout
`endif
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          ptr;
    logic          grant;
    logic          accept;
    logic          last_bit;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          id_r;

    logic fa_a;
    logic fa_b;
    logic fa_c;
    logic fa_s;
    logic fa_co;

    // The single shared full adder, fed from the LSBs of the operand shifters.
    assign fa_a  = a_sh[0];
    assign fa_b  = b_sh[0];
    assign fa_c  = carry;
    assign fa_s  = fa_a ^ fa_b ^ fa_c;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    // A lone valid wins outright; the pointer only breaks ties.
    assign grant    = (req0_valid & req1_valid) ? ptr : req1_valid;
    assign accept   = req0_ready | req1_ready;
    assign last_bit = (cnt == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)    next_state = ADD;
            ADD:     if (last_bit)  next_state = DONE;
            DONE:    if (res_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = ~rst & req0_valid & ~grant;
                req1_ready = ~rst & req1_valid & grant;
            end
            DONE:    res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            id_r   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= grant ? req1_a : req0_a;
                        b_sh  <= grant ? req1_b : req0_b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        id_r  <= grant;
                    end
                end
                ADD: begin
                    a_sh   <= {1'b0, a_sh[W-1:1]};
                    b_sh   <= {1'b0, b_sh[W-1:1]};
                    sum_sh <= {fa_s, sum_sh[W-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                end
                DONE: begin
                    if (res_ready) begin
                        ptr <= ~id_r;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_ARB_COUT_EN
    logic cout_r;

    // Captured on the final ADD edge so it lands together with the last sum bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_r <= 1'b0;
        end else if (state == ADD && last_bit) begin
            cout_r <= fa_co;
        end
    end

    assign res_cout = cout_r;
`endif

    assign res_sum = sum_sh;
    assign res_id  = id_r;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb/tb_serial_add_arbiter.sv - directed self-checking bench for serial_add_arbiter
module tb_serial_add_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         res_id;
    logic [W-1:0] res_sum;
`ifdef SERIAL_ADD_ARB_COUT_EN
    logic         res_cout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_add_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_sum    (res_sum)
`ifdef SERIAL_ADD_ARB_COUT_EN
        ,
        .res_cout   (res_cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_res(output int edges);
        edges = 0;
        while (!res_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // Called on a negedge with the DUT idle and res_ready=1.
    task automatic run_single(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_sum, input logic exp_cout, input string tag);
        int e;
        if (sel) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'(!sel));
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'(sel));
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_res(e);
        chk({tag, ".lat"}, 32'(e), 32'd8);
        chk({tag, ".sum"}, 32'(res_sum), 32'(exp_sum));
        chk({tag, ".id"},  32'(res_id),  32'(sel));
`ifdef SERIAL_ADD_ARB_COUT_EN
        chk({tag, ".cout"}, 32'(res_cout), 32'(exp_cout));
`else
        if (exp_cout === 1'bx) $display("note: %s carry unknown", tag);
`endif
        @(negedge clk);
        chk({tag, ".idle"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        int e;
        int cyc;
        int nres;
        int nacc;
        int nseen;
        logic [W-1:0] rsum [4];
        logic         rid  [4];
        int           acyc [4];
        logic         aid  [4];

        // Reset state, with a valid request held to prove ready stays low.
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.valid", 32'(res_valid), 32'd0);
        chk("rst.sum",   32'(res_sum),   32'd0);
        chk("rst.id",    32'(res_id),    32'd0);
        chk("rst.rdy0",  32'(req0_ready), 32'd0);
        chk("rst.rdy1",  32'(req1_ready), 32'd0);
`ifdef SERIAL_ADD_ARB_COUT_EN
        chk("rst.cout",  32'(res_cout),  32'd0);
`endif
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_single(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, "t029");
        run_single(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, "t030");
        run_single(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, "wrap");

        // Round robin from a fresh reset, both requesters always valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_a = 8'h01; req0_b = 8'h02;
        req1_a = 8'h10; req1_b = 8'h20;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rsum[i] = '0; rid[i] = 1'b0; acyc[i] = 0; aid[i] = 1'b0;
        end
        cyc = 0; nres = 0; nacc = 0;
        while (nres < 4 && cyc < 200) begin
            #1;
            if ((req0_ready | req1_ready) && nacc < 4) begin
                acyc[nacc] = cyc;
                aid[nacc]  = req1_ready;
                nacc++;
            end
            if (res_valid) begin
                rsum[nres] = res_sum;
                rid[nres]  = res_id;
                nres++;
            end
            @(negedge clk);
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr.nres", 32'(nres), 32'd4);
        chk("rr.nacc", 32'(nacc), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr.id%0d", i),   32'(rid[i]),  32'(i % 2));
            chk($sformatf("rr.aid%0d", i),  32'(aid[i]),  32'(i % 2));
            chk($sformatf("rr.sum%0d", i),  32'(rsum[i]), (i % 2) ? 32'h30 : 32'h03);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rr.period%0d", i), 32'(acyc[i+1] - acyc[i]), 32'd10);
        end

        // Back-pressure in DONE with req1 waiting.
        res_ready = 1'b0;
        req0_a = 8'h5A; req0_b = 8'h3C;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_a = 8'h01; req1_b = 8'h01;
        req1_valid = 1'b1;
        wait_res(e);
        chk("bp.lat", 32'(e), 32'd8);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp.valid%0d", i), 32'(res_valid),  32'd1);
            chk($sformatf("bp.sum%0d", i),   32'(res_sum),    32'h96);
            chk($sformatf("bp.id%0d", i),    32'(res_id),     32'd0);
            chk($sformatf("bp.rdy0_%0d", i), 32'(req0_ready), 32'd0);
            chk($sformatf("bp.rdy1_%0d", i), 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("bp.rdy1_done", 32'(req1_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("bp.rdy1_idle", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_res(e);
        chk("bp2.lat", 32'(e), 32'd8);
        chk("bp2.sum", 32'(res_sum), 32'h02);
        chk("bp2.id",  32'(res_id),  32'd1);
        @(negedge clk);

        // Leave the pointer at 1, then reset in the middle of an add.
        run_single(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, "pre");
        req0_a = 8'h5A; req0_b = 8'h3C;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid.valid", 32'(res_valid),  32'd0);
        chk("mid.sum",   32'(res_sum),    32'd0);
        chk("mid.id",    32'(res_id),     32'd0);
        chk("mid.rdy0",  32'(req0_ready), 32'd0);
        chk("mid.rdy1",  32'(req1_ready), 32'd0);
`ifdef SERIAL_ADD_ARB_COUT_EN
        chk("mid.cout",  32'(res_cout),   32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        nseen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) nseen++;
        end
        chk("mid.noresult", 32'(nseen), 32'd0);
        req0_a = 8'h5A; req0_b = 8'h3C;
        req1_a = 8'h11; req1_b = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("post.rdy0", 32'(req0_ready), 32'd1);
        chk("post.rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_res(e);
        chk("post.lat", 32'(e), 32'd8);
        chk("post.sum", 32'(res_sum), 32'h96);
        chk("post.id",  32'(res_id),  32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
